// File: rtl/md_seq.sv
// rtl/md_seq.sv - EX-stage mult/div sequencer: latches one request, drives the div/mul units, holds {HI,LO}
// Optional MD_DIVZERO_FAST_EN: a zero divisor skips the divider and completes as {dividend, 32'hFFFF_FFFF}.
module md_seq #(
  parameter int MUL_LAT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_op_valid,
  input  logic [1:0]  i_op_type,
  input  logic [31:0] i_opdata1,
  input  logic [31:0] i_opdata2,
  input  logic        i_flush,
  input  logic        i_ex_advance,
  output logic        o_stallreq,
  output logic        o_result_valid,
  output logic [63:0] o_result,
  output logic        o_div_start,
  output logic        o_div_signed,
  output logic [31:0] o_div_opdata1,
  output logic [31:0] o_div_opdata2,
  output logic        o_div_annul,
  input  logic        i_div_ready,
  input  logic [63:0] i_div_result,
  output logic        o_mul_signed,
  output logic [31:0] o_mul_ina,
  output logic [31:0] o_mul_inb,
  input  logic [63:0] i_mul_result
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIV_RUN = 2'd1,
    S_MUL_RUN = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [2:0] MUL_CNT_INIT = 3'(MUL_LAT - 1);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [1:0]  r_type;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [63:0] r_result;

  logic w_is_div;
  logic w_fast_dz;
  logic w_in_div;
  logic w_in_run;

  assign w_is_div = i_op_type[1];

`ifdef MD_DIVZERO_FAST_EN
  assign w_fast_dz = w_is_div & (i_opdata2 == 32'd0);
`else
  assign w_fast_dz = 1'b0;
`endif

  assign w_in_div = (r_state == S_DIV_RUN);
  assign w_in_run = w_in_div | (r_state == S_MUL_RUN);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_type   <= 2'd0;
      r_op1    <= 32'd0;
      r_op2    <= 32'd0;
      r_result <= 64'd0;
    end else if (i_flush) begin
      // A flush also drops a result that arrives in the same cycle.
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_op_valid) begin
            r_type <= i_op_type;
            r_op1  <= i_opdata1;
            r_op2  <= i_opdata2;
            if (w_fast_dz) begin
              r_result <= {i_opdata1, 32'hFFFF_FFFF};
              r_state  <= S_DONE;
            end else if (w_is_div) begin
              r_state <= S_DIV_RUN;
            end else begin
              r_cnt   <= MUL_CNT_INIT;
              r_state <= S_MUL_RUN;
            end
          end
        end
        S_DIV_RUN: begin
          if (i_div_ready) begin
            r_result <= i_div_result;
            r_state  <= S_DONE;
          end
        end
        S_MUL_RUN: begin
          if (r_cnt == 3'd0) begin
            r_result <= i_mul_result;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_DONE: begin
          // op_valid here still names the completed instruction, so only advance matters.
          if (i_ex_advance) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Combinational controls are gated by reset so they drop the instant reset asserts.
  assign o_stallreq     = ~i_rst & (((r_state == S_IDLE) & i_op_valid & ~i_flush) | w_in_run);
  assign o_div_start    = ~i_rst & w_in_div & ~i_div_ready & ~i_flush;
  assign o_div_annul    = ~i_rst & w_in_div & i_flush;
  assign o_result_valid = (r_state == S_DONE);
  assign o_result       = r_result;

  assign o_div_signed  = (r_state != S_IDLE) & (r_type == 2'b10);
  assign o_mul_signed  = (r_state != S_IDLE) & (r_type == 2'b00);
  assign o_div_opdata1 = r_op1;
  assign o_div_opdata2 = r_op2;
  assign o_mul_ina     = r_op1;
  assign o_mul_inb     = r_op2;

endmodule

// File: tb/tb_md_seq.sv
// tb/tb_md_seq.sv - self-checking bench for md_seq with behavioural div/mul units and a result scoreboard
module tb_md_seq;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op_type;
  logic [31:0] opdata1, opdata2;
  logic        flush, ex_advance;
  logic        stallreq, result_valid;
  logic [63:0] result;
  logic        div_start, div_signed, div_annul, div_ready;
  logic [31:0] div_opdata1, div_opdata2;
  logic [63:0] div_result;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  md_seq #(.MUL_LAT(MUL_LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_op_valid(op_valid), .i_op_type(op_type),
    .i_opdata1(opdata1), .i_opdata2(opdata2), .i_flush(flush), .i_ex_advance(ex_advance),
    .o_stallreq(stallreq), .o_result_valid(result_valid), .o_result(result),
    .o_div_start(div_start), .o_div_signed(div_signed), .o_div_opdata1(div_opdata1),
    .o_div_opdata2(div_opdata2), .o_div_annul(div_annul), .i_div_ready(div_ready),
    .i_div_result(div_result), .o_mul_signed(mul_signed), .o_mul_ina(mul_ina),
    .o_mul_inb(mul_inb), .i_mul_result(mul_result)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mul_ref(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  function automatic logic [63:0] div_ref(input logic s, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = a; sb = b; q = sa / sb; r = sa % sb;
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  always_comb mul_result = mul_ref(mul_signed, mul_ina, mul_inb);
  always_comb div_result = div_ref(div_signed, div_opdata1, div_opdata2);

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic settle(); #2; endtask

  task automatic idle_inputs();
    op_valid = 0; op_type = 0; opdata1 = 0; opdata2 = 0;
    flush = 0; ex_advance = 0; div_ready = 0;
  endtask

  task automatic wait_result(input int budget, output int n, output logic got);
    n = 0; got = 0;
    while (!got && n < budget) begin
      tick(); settle(); n++;
      if (result_valid) got = 1;
    end
  endtask

  task automatic retire();
    ex_advance = 1;
    tick(); ex_advance = 0; op_valid = 0; settle();
  endtask

  task automatic test_reset();
    checks++; if (stallreq !== 0 || result_valid !== 0 || div_start !== 0 || div_annul !== 0) begin
      errors++; $display("FAIL reset_ctrl got stall=%b rv=%b ds=%b an=%b want 0", stallreq, result_valid, div_start, div_annul); end
    checks++; if (result !== 64'd0 || div_opdata1 !== 0 || div_opdata2 !== 0 || mul_ina !== 0 || mul_inb !== 0) begin
      errors++; $display("FAIL reset_data got result=%h d1=%h d2=%h want 0", result, div_opdata1, div_opdata2); end
    tick(); rst = 0; settle();
    checks++; if (stallreq !== 0 || result_valid !== 0 || div_signed !== 0 || mul_signed !== 0) begin
      errors++; $display("FAIL reset_release got stall=%b rv=%b dsg=%b msg=%b want 0", stallreq, result_valid, div_signed, mul_signed); end
  endtask

  task automatic test_mul_latency();
    logic [1:0]  t_type[3] = '{2'b01, 2'b00, 2'b01};
    logic [31:0] t_a[3]    = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h7FFF_FFFF};
    logic [31:0] t_b[3]    = '{32'd2, 32'd5, 32'h7FFF_FFFF};
    logic [63:0] t_exp[3]  = '{64'h0000_0001_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF1, 64'h3FFF_FFFF_0000_0001};
    for (int k = 0; k < 3; k++) begin
      int stall_n, bad;
      logic [63:0] e;
      tick(); op_valid = 1; op_type = t_type[k]; opdata1 = t_a[k]; opdata2 = t_b[k];
      exp_q.push_back(t_exp[k]); settle();
      stall_n = stallreq ? 1 : 0; bad = 0;
      for (int c = 1; c <= MUL_LAT; c++) begin
        tick(); opdata1 = ~opdata1; settle();
        if (stallreq) stall_n++;
        if (result_valid || mul_ina !== t_a[k] || mul_inb !== t_b[k] || mul_signed !== (t_type[k] == 2'b00)) bad++;
      end
      tick(); settle();
      checks++; if (stall_n != MUL_LAT + 1 || bad != 0) begin
        errors++; $display("FAIL mul_run case %0d got stall_cycles=%0d bad=%0d want %0d,0", k, stall_n, bad, MUL_LAT + 1); end
      e = exp_q.pop_front();
      checks++; if (result_valid !== 1 || stallreq !== 0 || result !== e) begin
        errors++; $display("FAIL mul_result case %0d got rv=%b stall=%b result=%h want 1,0,%h", k, result_valid, stallreq, result, e); end
      retire();
      checks++; if (result_valid !== 0) begin
        errors++; $display("FAIL mul_retire case %0d got rv=%b want 0", k, result_valid); end
    end
  endtask

  task automatic test_div();
    int starts = 0, bad = 0;
    logic [63:0] e;
    tick(); op_valid = 1; op_type = 2'b10; opdata1 = 32'hFFFF_FFF9; opdata2 = 32'd2;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD}); settle();
    checks++; if (stallreq !== 1 || div_start !== 0) begin
      errors++; $display("FAIL div_accept got stall=%b ds=%b want 1,0", stallreq, div_start); end
    for (int c = 0; c < 33; c++) begin
      tick(); opdata1 = $urandom; settle();
      if (div_start) starts++;
      if (div_opdata1 !== 32'hFFFF_FFF9 || div_opdata2 !== 32'd2 || div_signed !== 1 || stallreq !== 1) bad++;
    end
    checks++; if (starts != 33 || bad != 0) begin
      errors++; $display("FAIL div_run got starts=%0d bad=%0d want 33,0", starts, bad); end
    tick(); div_ready = 1; settle();
    checks++; if (div_start !== 0 || stallreq !== 1 || result_valid !== 0) begin
      errors++; $display("FAIL div_ready_cycle got ds=%b stall=%b rv=%b want 0,1,0", div_start, stallreq, result_valid); end
    tick(); div_ready = 0; settle();
    e = exp_q.pop_front();
    checks++; if (result_valid !== 1 || result !== e || stallreq !== 0) begin
      errors++; $display("FAIL div_result got rv=%b result=%h want 1,%h", result_valid, result, e); end
    retire();
    checks++; if (result_valid !== 0 || div_signed !== 0) begin
      errors++; $display("FAIL div_retire got rv=%b dsg=%b want 0,0", result_valid, div_signed); end
  endtask

  task automatic test_flush();
    int annuls = 0, rv_seen = 0;
    tick(); op_valid = 1; op_type = 2'b11; opdata1 = 32'd100; opdata2 = 32'd7; settle();
    for (int c = 1; c < 10; c++) begin
      tick(); settle();
      if (div_annul) annuls++;
    end
    tick(); flush = 1; op_valid = 0; settle();
    checks++; if (div_annul !== 1 || div_start !== 0 || annuls != 0) begin
      errors++; $display("FAIL flush_annul got an=%b ds=%b early=%0d want 1,0,0", div_annul, div_start, annuls); end
    tick(); flush = 0; settle();
    checks++; if (div_annul !== 0 || stallreq !== 0 || div_start !== 0) begin
      errors++; $display("FAIL flush_idle got an=%b stall=%b ds=%b want 0,0,0", div_annul, stallreq, div_start); end
    div_ready = 1;
    for (int c = 0; c < 5; c++) begin
      tick(); settle();
      if (result_valid) rv_seen++;
    end
    div_ready = 0;
    tick(); op_valid = 1; op_type = 2'b10; opdata1 = 32'd50; opdata2 = 32'd5; settle();
    for (int c = 0; c < 3; c++) begin tick(); settle(); end
    tick(); div_ready = 1; flush = 1; op_valid = 0; settle();
    tick(); div_ready = 0; flush = 0; settle();
    for (int c = 0; c < 3; c++) begin
      if (result_valid) rv_seen++;
      tick(); settle();
    end
    checks++; if (rv_seen != 0) begin
      errors++; $display("FAIL flush_no_result got rv_cycles=%0d want 0", rv_seen); end
    tick(); op_valid = 1; flush = 1; op_type = 2'b00; settle();
    checks++; if (stallreq !== 0) begin
      errors++; $display("FAIL flush_in_idle got stall=%b want 0", stallreq); end
    tick(); op_valid = 0; flush = 0; settle();
    checks++; if (stallreq !== 0 || mul_signed !== 0) begin
      errors++; $display("FAIL flush_in_idle_next got stall=%b msg=%b want 0,0", stallreq, mul_signed); end
  endtask

  task automatic test_done_hold();
    int n, bad = 0;
    logic got;
    logic [63:0] e;
    tick(); op_valid = 1; op_type = 2'b00; opdata1 = 32'd6; opdata2 = 32'hFFFF_FFF9;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFD6); settle();
    wait_result(10, n, got);
    e = exp_q.pop_front();
    checks++; if (!got || result !== e) begin
      errors++; $display("FAIL hold_first got done=%b result=%h want 1,%h", got, result, e); end
    for (int c = 0; c < 5; c++) begin
      tick(); opdata1 = $urandom; settle();
      if (result_valid !== 1 || stallreq !== 0 || result !== e) bad++;
    end
    checks++; if (bad != 0) begin
      errors++; $display("FAIL hold_stable got bad_cycles=%0d want 0", bad); end
    ex_advance = 1;
    tick(); ex_advance = 0; op_valid = 1; op_type = 2'b00; opdata1 = 32'h0001_0000; opdata2 = 32'h0001_0000;
    exp_q.push_back(64'h0000_0001_0000_0000); settle();
    checks++; if (result_valid !== 0 || stallreq !== 1) begin
      errors++; $display("FAIL back_to_back_accept got rv=%b stall=%b want 0,1", result_valid, stallreq); end
    wait_result(10, n, got);
    e = exp_q.pop_front();
    checks++; if (!got || n != MUL_LAT + 1 || result !== e) begin
      errors++; $display("FAIL back_to_back_result got done=%b lat=%0d result=%h want 1,%0d,%h", got, n, result, MUL_LAT + 1, e); end
    retire();
  endtask

  task automatic test_async_reset();
    int n;
    logic got;
    logic [63:0] e;
    tick(); op_valid = 1; op_type = 2'b00; opdata1 = 32'd9; opdata2 = 32'hFFFF_FFFF; settle();
    tick(); settle();
    #1 rst = 1;
    #1;
    checks++; if (stallreq !== 0 || result_valid !== 0 || mul_signed !== 0 || mul_ina !== 0 || mul_inb !== 0 || result !== 0) begin
      errors++; $display("FAIL async_reset got stall=%b rv=%b msg=%b ina=%h result=%h want all 0", stallreq, result_valid, mul_signed, mul_ina, result); end
    tick(); rst = 0; op_valid = 0; settle();
    checks++; if (stallreq !== 0 || result_valid !== 0) begin
      errors++; $display("FAIL async_reset_idle got stall=%b rv=%b want 0,0", stallreq, result_valid); end
    tick(); op_valid = 1; op_type = 2'b01; opdata1 = 32'd3; opdata2 = 32'd4;
    exp_q.push_back(64'd12); settle();
    wait_result(10, n, got);
    e = exp_q.pop_front();
    checks++; if (!got || n != MUL_LAT + 1 || result !== e) begin
      errors++; $display("FAIL async_reset_recover got done=%b lat=%0d result=%h want 1,%0d,%h", got, n, result, MUL_LAT + 1, e); end
    retire();
  endtask

  task automatic test_divzero();
    int starts = 0, n;
    logic got;
    logic [63:0] e;
    tick(); op_valid = 1; op_type = 2'b11; opdata1 = 32'h1234_5678; opdata2 = 32'd0;
    exp_q.push_back({32'h1234_5678, 32'hFFFF_FFFF}); settle();
    checks++; if (stallreq !== 1) begin
      errors++; $display("FAIL divzero_accept got stall=%b want 1", stallreq); end
`ifdef MD_DIVZERO_FAST_EN
    tick(); settle();
    if (div_start) starts++;
    n = 1; got = result_valid;
    checks++; if (starts != 0) begin
      errors++; $display("FAIL divzero_start got starts=%0d want 0", starts); end
`else
    for (int c = 0; c < 5; c++) begin
      tick(); settle();
      if (div_start) starts++;
    end
    tick(); div_ready = 1; settle();
    tick(); div_ready = 0; settle();
    n = 7; got = result_valid;
    checks++; if (starts != 5) begin
      errors++; $display("FAIL divzero_start got starts=%0d want 5", starts); end
`endif
    e = exp_q.pop_front();
    checks++; if (!got || result !== e || stallreq !== 0) begin
      errors++; $display("FAIL divzero_result got rv=%b result=%h after %0d cycles want 1,%h", got, result, n, e); end
    retire();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_mul_latency();
    test_div();
    test_flush();
    test_done_hold();
    test_async_reset();
    test_divzero();
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
